imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, handshaked RISC-V immediate generator for all base formats (I/S/B/U/J), parametrised in XLEN.
//  Sits between IF/ID and the ID-stage operand mux and decouples decode from downstream stalls.
//  A 2-entry skid buffer keeps in_ready_o free of any combinational path from out_ready_i.
// PARAMETERS
//  XLEN                32  immediate/output width; legal values 32 or 64
//  TAG_W               32  width of sideband tag (PC) carried alongside each instruction
//  BRANCH_BYTE_OFFSET  0   0: B imm = sext(imm[12:1]) (halfword count, current datapath); 1: sext({imm[12:1],1'b0}) (byte offset)
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      synchronous reset, ACTIVE-LOW
//  flush_i        in   1      synchronous drop of all buffered entries
//  in_valid_i     in   1      instruction offered
//  in_ready_o     out  1      block can accept this cycle
//  instr_i        in   32     raw instruction word
//  tag_i          in   TAG_W  sideband (PC), passed through unchanged
//  out_valid_o    out  1      result available
//  out_ready_i    in   1      consumer takes result this cycle
//  imm_o          out  XLEN   sign-extended immediate
//  fmt_o          out  3      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//  tag_o          out  TAG_W  tag of the presented entry
// BEHAVIOUR
//  - Clock clk_i; reset rst_i is synchronous and active-low. While rst_i==0: out_valid_o=0, imm_o=0, fmt_o=0, tag_o=0, skid cleared, in_ready_o=0.
//  - Opcode decode on instr_i[6:0]: 0010011/0000011/1100111 -> I, imm[11:0]=instr[31:20]; 0100011 -> S, {instr[31:25],instr[11:7]};
//    1100011 -> B, {instr[31],instr[7],instr[30:25],instr[11:8]} (shifted per BRANCH_BYTE_OFFSET);
//    0110111/0010111 -> U, {instr[31:12],12'b0}; 1101111 -> J, {instr[31],instr[19:12],instr[20],instr[30:21]} then as B w.r.t. bit0.
//  - All formats sign-extend from instr[31] to full XLEN (U included, so XLEN=64 lui sign-extends bit 31).
//  - Any other opcode: fmt_o=NONE, imm_o=all-zero (every bit driven; no retained/latched bits).
//  - Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when buffer empty.
//  - Handshake: transfer on valid&&ready at each side. out_valid_o/imm_o/fmt_o/tag_o stable while out_valid_o&&!out_ready_i.
//  - in_ready_o = rst_i && !skid_valid (registered state only; no path from out_ready_i).
//  - States: EMPTY (no entries), ONE (output reg valid), FULL (output + skid valid).
//    EMPTY: accept -> ONE.  ONE: accept&&!pop -> FULL; pop&&!accept -> EMPTY; accept&&pop -> ONE (new data).
//    FULL: pop -> ONE (skid moves to output reg); no accept possible.
//  - Order strictly FIFO; no entry dropped or duplicated except by flush_i/reset.
//  - flush_i=1: next state EMPTY, out_valid_o=0; input offered in the same cycle is NOT accepted; flush beats accept and pop.
//  - Reset mid-transfer: all entries discarded, identical to flush plus output data zeroed.
// CONFIGURATION
//  IMM_GEN_ERR_EN defined: adds port err_o (out, 1), registered with its entry; 1 when the entry's opcode decodes to NONE
//    or instr_i[1:0]!=2'b11; reset/flush value 0; held stable under backpressure like imm_o.
//  IMM_GEN_ERR_EN undefined: no err_o port, no associated logic; all other behaviour identical.
// TESTING
//  1 XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle imm_o=0xFFFFFFFF, fmt_o=1, out_valid_o=1.
//  2 instr 0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, fmt_o=2.
//  3 instr 0xFE000CE3 (beq -8): BRANCH_BYTE_OFFSET=0 -> 0xFFFFFFFC; =1 -> 0xFFFFFFF8; fmt_o=3.
//  4 instr 0x123450B7 -> imm 0x12345000, fmt 4; XLEN=64, instr 0x800000B7 -> 0xFFFFFFFF80000000.
//  5 out_ready_i=0, offer A,B,C back-to-back -> A,B held, in_ready_o=0 after 2nd accept, C stalled;
//    raise out_ready_i -> A,B,C emerge in order, tags intact.
//  6 FULL buffer, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, offered input never emerges;
//    with IMM_GEN_ERR_EN, instr 0x00000033 -> fmt_o=0, imm_o=0, err_o=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RISC-V immediate generator (I/S/B/U/J) with a 2-entry skid buffer.
// Optional err_o output enabled by defining IMM_GEN_ERR_EN.
module imm_gen_pipe #(
    parameter int XLEN               = 32,
    parameter int TAG_W              = 32,
    parameter bit BRANCH_BYTE_OFFSET = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
`ifdef IMM_GEN_ERR_EN
    output logic             err_o,
`endif
    output logic [TAG_W-1:0] tag_o
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ERR_EN
        logic             err;
`endif
    } entry_t;

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t dec;

    logic [6:0]  opc;
    logic [31:0] imm32;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic        is_i, is_s, is_b, is_u, is_j;
    logic        accept, pop;

    assign opc  = instr_i[6:0];
    assign is_i = (opc == 7'b0010011) || (opc == 7'b0000011) ||
                  (opc == 7'b1100111);
    assign is_s = (opc == 7'b0100011);
    assign is_b = (opc == 7'b1100011);
    assign is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
    assign is_j = (opc == 7'b1101111);

    // B/J fields as halfword counts; byte-offset builds shift them left once
    assign b_imm = {{20{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8]};
    assign j_imm = {{12{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21]};

    always_comb begin
        imm32   = '0;
        dec     = '0;
        dec.fmt = FMT_NONE;
        unique case (1'b1)
            is_i: begin
                imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                dec.fmt = FMT_I;
            end
            is_s: begin
                imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                dec.fmt = FMT_S;
            end
            is_b: begin
                imm32   = BRANCH_BYTE_OFFSET ? {b_imm[30:0], 1'b0} : b_imm;
                dec.fmt = FMT_B;
            end
            is_u: begin
                imm32   = {instr_i[31:12], 12'b0};
                dec.fmt = FMT_U;
            end
            is_j: begin
                imm32   = BRANCH_BYTE_OFFSET ? {j_imm[30:0], 1'b0} : j_imm;
                dec.fmt = FMT_J;
            end
            default: ;
        endcase
        dec.imm        = {XLEN{imm32[31]}};
        dec.imm[31:0]  = imm32;
        dec.tag        = tag_i;
`ifdef IMM_GEN_ERR_EN
        dec.err        = (dec.fmt == FMT_NONE) || (instr_i[1:0] != 2'b11);
`endif
    end

    assign in_ready_o  = rst_i && (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    out_d   = dec;
                    state_d = ONE;
                end
                ONE: if (accept && pop) begin
                    out_d   = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign imm_o = out_q.imm;
    assign fmt_o = out_q.fmt;
    assign tag_o = out_q.tag;
`ifdef IMM_GEN_ERR_EN
    assign err_o = out_q.err;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: queue model plus directed vectors.
// Two instances: XLEN=32 halfword branches, XLEN=64 byte branches.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] tag = '0;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] imm0, tag0, tag1;
    logic [63:0] imm1;
    logic [2:0]  fmt0, fmt1;
`ifdef IMM_GEN_ERR_EN
    logic        err0, err1;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] qi[$];
    logic [31:0] qt[$];
    logic        rst_m = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .BRANCH_BYTE_OFFSET(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .instr_i(instr), .tag_i(tag),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .imm_o(imm0), .fmt_o(fmt0),
`ifdef IMM_GEN_ERR_EN
        .err_o(err0),
`endif
        .tag_o(tag0)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .BRANCH_BYTE_OFFSET(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .instr_i(instr), .tag_i(tag),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .imm_o(imm1), .fmt_o(fmt1),
`ifdef IMM_GEN_ERR_EN
        .err_o(err1),
`endif
        .tag_o(tag1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate as a plain signed number; B/J optionally doubled to bytes
    function automatic logic [63:0] m_imm(input logic [31:0] i,
                                          input bit boff);
        longint v;
        v = 0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: v = $signed(i[31:20]);
            7'h23: v = $signed({i[31:25], i[11:7]});
            7'h63: v = $signed({i[31], i[7], i[30:25], i[11:8]});
            7'h37, 7'h17: v = $signed({i[31:12], 12'h000});
            7'h6F: v = $signed({i[31], i[19:12], i[20], i[30:21]});
            default: v = 0;
        endcase
        if (boff && (i[6:0] == 7'h63 || i[6:0] == 7'h6F)) v = v * 2;
        return v;
    endfunction

    function automatic logic [2:0] m_fmt(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        int  n;
        bit  p, a;
        n = qi.size();
        if (!rst || flush) begin
            qi.delete();
            qt.delete();
        end else begin
            p = (n > 0) && out_ready;
            a = in_valid && (n < 2);
            if (p) begin
                void'(qi.pop_front());
                void'(qt.pop_front());
            end
            if (a) begin
                qi.push_back(instr);
                qt.push_back(tag);
            end
        end
        rst_m = rst;
    end

    always @(negedge clk) begin
        logic [63:0] e0, e1;
        chk("in_ready0", {63'd0, in_ready0}, {63'd0, rst && qi.size() < 2});
        chk("in_ready1", {63'd0, in_ready1}, {63'd0, rst && qi.size() < 2});
        chk("out_valid0", {63'd0, out_valid0}, {63'd0, qi.size() > 0});
        chk("out_valid1", {63'd0, out_valid1}, {63'd0, qi.size() > 0});
        if (!rst_m) begin
            chk("rst_imm0", {32'd0, imm0}, 64'd0);
            chk("rst_imm1", imm1, 64'd0);
            chk("rst_fmt0", {61'd0, fmt0}, 64'd0);
            chk("rst_tag0", {32'd0, tag0}, 64'd0);
        end else if (qi.size() > 0) begin
            e0 = m_imm(qi[0], 1'b0);
            e1 = m_imm(qi[0], 1'b1);
            chk("imm0", {32'd0, imm0}, {32'd0, e0[31:0]});
            chk("imm1", imm1, e1);
            chk("fmt0", {61'd0, fmt0}, {61'd0, m_fmt(qi[0])});
            chk("fmt1", {61'd0, fmt1}, {61'd0, m_fmt(qi[0])});
            chk("tag0", {32'd0, tag0}, {32'd0, qt[0]});
            chk("tag1", {32'd0, tag1}, {32'd0, qt[0]});
`ifdef IMM_GEN_ERR_EN
            chk("err0", {63'd0, err0},
                {63'd0, m_fmt(qi[0]) == 3'd0 || qi[0][1:0] != 2'b11});
            chk("err1", {63'd0, err1}, {63'd0, err0 === 1'b1 ? 1'b1 :
                (m_fmt(qi[0]) == 3'd0 || qi[0][1:0] != 2'b11)});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] t);
        instr    = i;
        tag      = t;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] tbl [10] = '{32'h00500113, 32'h80002083, 32'h00A12423,
                              32'h7E000FE3, 32'hFFFFF537, 32'h00001597,
                              32'hFFDFF0EF, 32'h000080E7, 32'h00000033,
                              32'h8000006F};
    logic [31:0] got[$];
    bit          acc;

    initial begin
        repeat (3) step();
        chk("reset_valid", {63'd0, out_valid0}, 64'd0);
        chk("reset_ready", {63'd0, in_ready0}, 64'd0);
        chk("reset_imm", {32'd0, imm0}, 64'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();

        send(32'hFFF00093, 32'h1);
        chk("addi_imm", {32'd0, imm0}, 64'hFFFFFFFF);
        chk("addi_fmt", {61'd0, fmt0}, 64'd1);
        chk("addi_valid", {63'd0, out_valid0}, 64'd1);
        send(32'hFE112E23, 32'h2);
        chk("sw_imm", {32'd0, imm0}, 64'hFFFFFFFC);
        chk("sw_fmt", {61'd0, fmt0}, 64'd2);
        send(32'hFE000CE3, 32'h3);
        chk("beq_imm_half", {32'd0, imm0}, 64'hFFFFFFFC);
        chk("beq_imm_byte", imm1, 64'hFFFFFFFFFFFFFFF8);
        chk("beq_fmt", {61'd0, fmt0}, 64'd3);
        send(32'h123450B7, 32'h4);
        chk("lui_imm", {32'd0, imm0}, 64'h12345000);
        chk("lui_fmt", {61'd0, fmt0}, 64'd4);
        send(32'h800000B7, 32'h5);
        chk("lui64_imm", imm1, 64'hFFFFFFFF80000000);
        chk("lui32_imm", {32'd0, imm0}, 64'h80000000);
        send(32'h0080006F, 32'h6);
        chk("jal_imm_half", {32'd0, imm0}, 64'd4);
        chk("jal_imm_byte", imm1, 64'd8);
        chk("jal_fmt", {61'd0, fmt1}, 64'd5);
        send(32'h00000033, 32'h7);
        chk("none_imm", {32'd0, imm0}, 64'd0);
        chk("none_fmt", {61'd0, fmt0}, 64'd0);
`ifdef IMM_GEN_ERR_EN
        chk("none_err", {63'd0, err0}, 64'd1);
`endif
        step();

        for (int k = 0; k < 10; k++) begin
            instr    = tbl[k];
            tag      = 32'd100 + k;
            in_valid = 1'b1;
            acc      = 1'b0;
            for (int c = 0; c < 20 && !acc; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                acc       = in_ready0;
                step();
            end
            if (!acc) chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (4) step();

        out_ready = 1'b0;
        send(32'h00100093, 32'hA0);
        send(32'h00200093, 32'hB0);
        chk("full_ready", {63'd0, in_ready0}, 64'd0);
        chk("full_head", {32'd0, tag0}, 64'hA0);
        instr    = 32'h00300093;
        tag      = 32'hC0;
        in_valid = 1'b1;
        repeat (2) step();
        chk("stall_head", {32'd0, tag0}, 64'hA0);
        chk("stall_ready", {63'd0, in_ready0}, 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            if (out_valid0) got.push_back(tag0);
            acc = in_valid && in_ready0;
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("order_count", 64'(got.size()), 64'd3);
        chk("order_0", {32'd0, got.size() > 0 ? got[0] : 32'hDEAD}, 64'hA0);
        chk("order_1", {32'd0, got.size() > 1 ? got[1] : 32'hDEAD}, 64'hB0);
        chk("order_2", {32'd0, got.size() > 2 ? got[2] : 32'hDEAD}, 64'hC0);
        in_valid = 1'b0;
        repeat (2) step();

        out_ready = 1'b0;
        send(32'h00400093, 32'hD1);
        send(32'h00500093, 32'hD2);
        flush    = 1'b1;
        instr    = 32'h00600093;
        tag      = 32'hDD;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'd0, out_valid0}, 64'd0);
        chk("flush_ready", {63'd0, in_ready0}, 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("flush_dropped", {63'd0, out_valid0}, 64'd0);
        end

        out_ready = 1'b0;
        send(32'hFFF00093, 32'hE1);
        send(32'hFFF00093, 32'hE2);
        rst = 1'b0;
        step();
        chk("midrst_valid", {63'd0, out_valid0}, 64'd0);
        chk("midrst_imm", {32'd0, imm0}, 64'd0);
        chk("midrst_tag", {32'd0, tag0}, 64'd0);
        rst = 1'b1;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
